// File: rtl/wb_write_arbiter_if.sv
// Writeback request / regfile write-port bundle between the FU writeback buses
// and the physical regfile, shared by the arbiter and its requesters.
interface wb_write_arbiter_if #(
  parameter int NUM_WR         = 6,
  parameter int NUM_PORT       = 2,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int REG_DATA_WIDTH = 64
);
  logic [NUM_WR-1:0]                  wr_valid;
  logic [NUM_WR-1:0]                  wr_ready;
  logic [NUM_WR*REG_ADDR_WIDTH-1:0]   wr_address;
  logic [NUM_WR*REG_DATA_WIDTH-1:0]   wr_data;
  logic [NUM_PORT-1:0]                port_valid;
  logic [NUM_PORT*REG_ADDR_WIDTH-1:0] port_address;
  logic [NUM_PORT*REG_DATA_WIDTH-1:0] port_data;

  modport master (
    output wr_valid, wr_address, wr_data,
    input  wr_ready, port_valid, port_address, port_data
  );

  modport slave (
    input  wr_valid, wr_address, wr_data,
    output wr_ready, port_valid, port_address, port_data
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Round-robin writeback arbiter: NUM_WR request channels, each backed by a small
// FIFO, share NUM_PORT regfile write ports; losers are buffered, not dropped.
module wb_write_arbiter #(
  parameter int NUM_WR         = 6,
  parameter int NUM_PORT       = 2,
  parameter int BUF_DEPTH      = 2,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int REG_DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  wb_write_arbiter_if.slave     bus
);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int CH_W  = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;
  localparam int AW    = REG_ADDR_WIDTH;
  localparam int DW    = REG_DATA_WIDTH;

  logic [AW-1:0]    buf_addr_r [NUM_WR][BUF_DEPTH];
  logic [DW-1:0]    buf_data_r [NUM_WR][BUF_DEPTH];
  logic [PTR_W-1:0] head_r     [NUM_WR];
  logic [PTR_W-1:0] tail_r     [NUM_WR];
  logic [CNT_W-1:0] count_r    [NUM_WR];
  logic [CH_W-1:0]  rr_r;

  logic                   kill_s;
  logic [NUM_WR-1:0]      wr_ready_s;
  logic [NUM_WR-1:0]      accept_s;
  logic [NUM_WR-1:0]      cand_s;
  logic [AW-1:0]          cand_addr_s [NUM_WR];
  logic [DW-1:0]          cand_data_s [NUM_WR];
  logic [NUM_WR-1:0]      grant_s;
  logic [NUM_WR-1:0]      push_s;
  logic [NUM_WR-1:0]      pop_s;
  logic [CH_W-1:0]        rr_next_s;
  logic [NUM_PORT-1:0]    port_valid_s;
  logic [NUM_PORT*AW-1:0] port_address_s;
  logic [NUM_PORT*DW-1:0] port_data_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
  endfunction

  assign kill_s = rst | flush;

  // Per-channel readiness and candidate: buffered head wins over the live input.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      wr_ready_s[i] = (count_r[i] < CNT_W'(BUF_DEPTH)) & ~kill_s;
      accept_s[i]   = bus.wr_valid[i] & wr_ready_s[i];
      if (count_r[i] != CNT_W'(0)) begin
        cand_s[i]      = ~kill_s;
        cand_addr_s[i] = buf_addr_r[i][head_r[i]];
        cand_data_s[i] = buf_data_r[i][head_r[i]];
      end else begin
        cand_s[i]      = accept_s[i];
        cand_addr_s[i] = bus.wr_address[i*AW +: AW];
        cand_data_s[i] = bus.wr_data[i*DW +: DW];
      end
    end
  end

  // Round-robin scan from rr_r; the k-th candidate found drives port k.
  always_comb begin
    int ch_idx;
    int n_grant;
    grant_s        = NUM_WR'(0);
    rr_next_s      = rr_r;
    port_valid_s   = NUM_PORT'(0);
    port_address_s = (NUM_PORT*AW)'(0);
    port_data_s    = (NUM_PORT*DW)'(0);
    n_grant        = 0;
    ch_idx         = 0;
    for (int off = 0; off < NUM_WR; off++) begin
      ch_idx = int'(rr_r) + off;
      if (ch_idx >= NUM_WR) begin
        ch_idx = ch_idx - NUM_WR;
      end else begin
        ch_idx = ch_idx;
      end
      if (cand_s[ch_idx] && (n_grant < NUM_PORT)) begin
        grant_s[ch_idx]                     = 1'b1;
        port_valid_s[n_grant]               = 1'b1;
        port_address_s[n_grant*AW +: AW]    = cand_addr_s[ch_idx];
        port_data_s[n_grant*DW +: DW]       = cand_data_s[ch_idx];
        rr_next_s = (ch_idx == NUM_WR - 1) ? CH_W'(0) : CH_W'(ch_idx + 1);
        n_grant   = n_grant + 1;
      end else begin
        n_grant = n_grant;
      end
    end
  end

  // A granted bypass is never stored; an accepted input that lost is pushed.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      pop_s[i]  = grant_s[i] & (count_r[i] != CNT_W'(0));
      push_s[i] = accept_s[i] & ~(grant_s[i] & (count_r[i] == CNT_W'(0)));
    end
  end

  // FIFO bookkeeping and round-robin pointer; flush keeps rr_r, reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_r <= CH_W'(0);
      for (int i = 0; i < NUM_WR; i++) begin
        head_r[i]  <= PTR_W'(0);
        tail_r[i]  <= PTR_W'(0);
        count_r[i] <= CNT_W'(0);
      end
    end else if (flush) begin
      rr_r <= rr_r;
      for (int i = 0; i < NUM_WR; i++) begin
        head_r[i]  <= PTR_W'(0);
        tail_r[i]  <= PTR_W'(0);
        count_r[i] <= CNT_W'(0);
      end
    end else begin
      rr_r <= rr_next_s;
      for (int i = 0; i < NUM_WR; i++) begin
        head_r[i]  <= pop_s[i]  ? ptr_inc(head_r[i]) : head_r[i];
        tail_r[i]  <= push_s[i] ? ptr_inc(tail_r[i]) : tail_r[i];
        count_r[i] <= count_r[i] + CNT_W'(push_s[i]) - CNT_W'(pop_s[i]);
      end
    end
  end

  // FIFO payload storage; validity is tracked solely by the counters.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_WR; i++) begin
      if (push_s[i]) begin
        buf_addr_r[i][tail_r[i]] <= bus.wr_address[i*AW +: AW];
        buf_data_r[i][tail_r[i]] <= bus.wr_data[i*DW +: DW];
      end else begin
        buf_addr_r[i][tail_r[i]] <= buf_addr_r[i][tail_r[i]];
        buf_data_r[i][tail_r[i]] <= buf_data_r[i][tail_r[i]];
      end
    end
  end

  assign bus.wr_ready     = wr_ready_s;
  assign bus.port_valid   = port_valid_s;
  assign bus.port_address = port_address_s;
  assign bus.port_data    = port_data_s;
endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: a BUF_DEPTH=2 instance for the main
// sequence and a BUF_DEPTH=1 instance for the full-FIFO push/pop boundary.
module tb_wb_write_arbiter;
  logic clk;
  logic rst;
  logic flush;
  int   checks;
  int   errors;

  wb_write_arbiter_if #(.NUM_WR(6), .NUM_PORT(2), .REG_ADDR_WIDTH(6), .REG_DATA_WIDTH(64)) bus1 ();
  wb_write_arbiter_if #(.NUM_WR(6), .NUM_PORT(2), .REG_ADDR_WIDTH(6), .REG_DATA_WIDTH(64)) bus2 ();

  wb_write_arbiter #(.NUM_WR(6), .NUM_PORT(2), .BUF_DEPTH(2), .REG_ADDR_WIDTH(6), .REG_DATA_WIDTH(64))
    dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus1));

  wb_write_arbiter #(.NUM_WR(6), .NUM_PORT(2), .BUF_DEPTH(1), .REG_ADDR_WIDTH(6), .REG_DATA_WIDTH(64))
    dut_d1 (.clk(clk), .rst(rst), .flush(1'b0), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] addr_of(input int ch, input int item);
    return 6'(ch * 8 + item);
  endfunction

  function automatic logic [63:0] data_of(input int ch, input int item);
    return 64'hCAFE_0000_0000_0000 | 64'(ch * 256 + item);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // c0/c1 < 0 means that port must be idle with zero address/data.
  task automatic chk_ports(input string tag, input logic [1:0] ov, input logic [11:0] oa,
                           input logic [127:0] od, input int c0, input int i0,
                           input int c1, input int i1);
    logic [1:0]   ev;
    logic [11:0]  ea;
    logic [127:0] ed;
    ev = 2'b00;
    ea = 12'h000;
    ed = 128'h0;
    if (c0 >= 0) begin
      ev[0] = 1'b1; ea[5:0] = addr_of(c0, i0); ed[63:0] = data_of(c0, i0);
    end
    if (c1 >= 0) begin
      ev[1] = 1'b1; ea[11:6] = addr_of(c1, i1); ed[127:64] = data_of(c1, i1);
    end
    chk({tag, "_valid"}, 128'(ov), 128'(ev));
    chk({tag, "_addr"},  128'(oa), 128'(ea));
    chk({tag, "_data"},  od, ed);
  endtask

  task automatic drv1(input int ch, input int item);
    bus1.wr_valid[ch]          = 1'b1;
    bus1.wr_address[ch*6 +: 6] = addr_of(ch, item);
    bus1.wr_data[ch*64 +: 64]  = data_of(ch, item);
  endtask

  task automatic drv2(input int ch, input int item);
    bus2.wr_valid[ch]          = 1'b1;
    bus2.wr_address[ch*6 +: 6] = addr_of(ch, item);
    bus2.wr_data[ch*64 +: 64]  = data_of(ch, item);
  endtask

  task automatic all1(input int it0, input int it1, input int it2,
                      input int it3, input int it4, input int it5);
    drv1(0, it0); drv1(1, it1); drv1(2, it2); drv1(3, it3); drv1(4, it4); drv1(5, it5);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    bus1.wr_valid = 6'h3f; bus1.wr_address = 36'h0; bus1.wr_data = 384'h0;
    bus2.wr_valid = 6'h00; bus2.wr_address = 36'h0; bus2.wr_data = 384'h0;

    // Reset held: ready and ports forced low even with all requests valid.
    @(negedge clk); @(negedge clk); #2;
    chk("rst_ready", 128'(bus1.wr_ready), 128'h0);
    chk_ports("rst_port", bus1.port_valid, bus1.port_address, bus1.port_data, -1, 0, -1, 0);
    @(negedge clk); rst = 1'b0; bus1.wr_valid = 6'h00; #2;
    chk("post_rst_ready", 128'(bus1.wr_ready), 128'h3f);
    chk("post_rst_ready_d1", 128'(bus2.wr_ready), 128'h3f);
    chk_ports("post_rst", bus1.port_valid, bus1.port_address, bus1.port_data, -1, 0, -1, 0);

    // Two bypass writes in the same cycle.
    @(negedge clk);
    bus1.wr_valid = 6'b000101;
    bus1.wr_address[0 +: 6]  = 6'd3;  bus1.wr_data[0 +: 64]   = 64'h1111;
    bus1.wr_address[12 +: 6] = 6'd7;  bus1.wr_data[128 +: 64] = 64'h2222;
    #2;
    chk("t1_valid", 128'(bus1.port_valid), 128'h3);
    chk("t1_addr", 128'(bus1.port_address), 128'({6'd7, 6'd3}));
    chk("t1_data", bus1.port_data, {64'h2222, 64'h1111});
    @(negedge clk); bus1.wr_valid = 6'h00; #2;
    chk_ports("t2_empty", bus1.port_valid, bus1.port_address, bus1.port_data, -1, 0, -1, 0);
    // rr is 3: ch5 must outrank ch0.
    @(negedge clk); drv1(0, 1); drv1(5, 1); #2;
    chk_ports("t3_rr3", bus1.port_valid, bus1.port_address, bus1.port_data, 5, 1, 0, 1);
    @(negedge clk); bus1.wr_valid = 6'h00; drv1(5, 2); #2;
    chk_ports("t4_ch5", bus1.port_valid, bus1.port_address, bus1.port_data, 5, 2, -1, 0);

    // Full load from rr=0; ch4/ch5 then ch0..3 fill and drop ready.
    @(negedge clk); all1(0, 0, 0, 0, 0, 0); #2;
    chk_ports("A", bus1.port_valid, bus1.port_address, bus1.port_data, 0, 0, 1, 0);
    chk("A_ready", 128'(bus1.wr_ready), 128'h3f);
    @(negedge clk); all1(1, 1, 1, 1, 1, 1); #2;
    chk_ports("B", bus1.port_valid, bus1.port_address, bus1.port_data, 2, 0, 3, 0);
    chk("B_ready", 128'(bus1.wr_ready), 128'h3f);
    @(negedge clk); all1(2, 2, 2, 2, 2, 2); #2;
    chk_ports("C", bus1.port_valid, bus1.port_address, bus1.port_data, 4, 0, 5, 0);
    chk("C_ready", 128'(bus1.wr_ready), 128'b110000 ^ 128'h3f);
    @(negedge clk); all1(3, 3, 3, 3, 2, 2); #2;
    chk_ports("D", bus1.port_valid, bus1.port_address, bus1.port_data, 0, 1, 1, 1);
    chk("D_ready", 128'(bus1.wr_ready), 128'b110000);
    @(negedge clk); bus1.wr_valid = 6'h00; #2;
    chk_ports("E", bus1.port_valid, bus1.port_address, bus1.port_data, 2, 1, 3, 1);
    chk("E_ready", 128'(bus1.wr_ready), 128'b000011);
    @(negedge clk); #2;
    chk_ports("F", bus1.port_valid, bus1.port_address, bus1.port_data, 4, 1, 5, 1);
    chk("F_ready", 128'(bus1.wr_ready), 128'b001111);
    @(negedge clk); #2;
    chk_ports("G", bus1.port_valid, bus1.port_address, bus1.port_data, 0, 2, 1, 2);
    @(negedge clk); #2;
    chk_ports("H", bus1.port_valid, bus1.port_address, bus1.port_data, 2, 2, 3, 2);
    @(negedge clk); #2;
    chk_ports("I", bus1.port_valid, bus1.port_address, bus1.port_data, 4, 2, 5, 2);
    @(negedge clk); #2;
    chk_ports("J_drained", bus1.port_valid, bus1.port_address, bus1.port_data, -1, 0, -1, 0);

    // Fill FIFOs, flush, confirm nothing stale and rr_ptr kept.
    @(negedge clk); all1(5, 5, 5, 5, 5, 5); #2;
    chk_ports("K", bus1.port_valid, bus1.port_address, bus1.port_data, 0, 5, 1, 5);
    @(negedge clk); flush = 1'b1; all1(6, 6, 6, 6, 6, 6); #2;
    chk_ports("L_flush", bus1.port_valid, bus1.port_address, bus1.port_data, -1, 0, -1, 0);
    chk("L_flush_ready", 128'(bus1.wr_ready), 128'h0);
    @(negedge clk); flush = 1'b0; bus1.wr_valid = 6'h00; #2;
    chk_ports("M_post_flush", bus1.port_valid, bus1.port_address, bus1.port_data, -1, 0, -1, 0);
    chk("M_ready", 128'(bus1.wr_ready), 128'h3f);
    @(negedge clk); drv1(0, 7); drv1(3, 7); #2;
    chk_ports("N_rr_kept", bus1.port_valid, bus1.port_address, bus1.port_data, 3, 7, 0, 7);
    @(negedge clk); bus1.wr_valid = 6'h00;

    // BUF_DEPTH=1: full FIFO being popped still reports not-ready.
    drv2(0, 0); drv2(1, 0); drv2(2, 0); #2;
    chk_ports("P", bus2.port_valid, bus2.port_address, bus2.port_data, 0, 0, 1, 0);
    @(negedge clk); bus2.wr_valid = 6'h00; drv2(2, 1); #2;
    chk("Q_ready", 128'(bus2.wr_ready), 128'b111011);
    chk_ports("Q", bus2.port_valid, bus2.port_address, bus2.port_data, 2, 0, -1, 0);
    @(negedge clk); #2;
    chk("R_ready", 128'(bus2.wr_ready), 128'h3f);
    chk_ports("R_bypass", bus2.port_valid, bus2.port_address, bus2.port_data, 2, 1, -1, 0);
    @(negedge clk); bus2.wr_valid = 6'h00; #2;
    chk_ports("S_empty", bus2.port_valid, bus2.port_address, bus2.port_data, -1, 0, -1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
